cu_seq: RTL

Sequencing control unit for the autoencoder datapath. It fetches instructions from a synchronous instruction memory, decodes them into the ALU, memory and activation-destination control strobes, and waits on a done handshake for ALU operations. It supports optional hardware loops, HALT and sticky illegal-opcode reporting. It sits between the instruction ROM and the datapath (ALU, data memory, sigmoid/ReLU units).

---
 rtl/cu_pkg.sv | 47 ++++
 rtl/cu_decode.sv | 59 +++++
 rtl/cu_seq.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/cu_pkg.sv
// Shared opcodes, strobe encodings, FSM states and decoded control bundle for
// the cu_seq sequencer. The CU_LOOP_EN macro enables the hardware-loop opcodes.
package cu_pkg;

  localparam int unsigned OPC_W = 4;

  localparam logic [3:0] OPC_ADD    = 4'b0000;
  localparam logic [3:0] OPC_SUB    = 4'b0001;
  localparam logic [3:0] OPC_MUL    = 4'b0010;
  localparam logic [3:0] OPC_MEMW   = 4'b0011;
  localparam logic [3:0] OPC_MEMSEL = 4'b0100;
  localparam logic [3:0] OPC_SIG    = 4'b0101;
  localparam logic [3:0] OPC_RELU   = 4'b0110;
  localparam logic [3:0] OPC_DSIG   = 4'b0111;
  localparam logic [3:0] OPC_LOOP   = 4'b1000;
  localparam logic [3:0] OPC_DJNZ   = 4'b1001;
  localparam logic [3:0] OPC_HALT   = 4'b1110;
  localparam logic [3:0] OPC_NOP    = 4'b1111;

  localparam logic [1:0] OPSEL_ADD = 2'b00;
  localparam logic [1:0] OPSEL_SUB = 2'b01;
  localparam logic [1:0] OPSEL_MUL = 2'b10;

  localparam logic [1:0] DEST_NONE = 2'b00;
  localparam logic [1:0] DEST_SIG  = 2'b01;
  localparam logic [1:0] DEST_RELU = 2'b10;
  localparam logic [1:0] DEST_DSIG = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

  typedef struct packed {
    logic       en_alu;
    logic [1:0] op_sel;
    logic       en_write_mem;
    logic       en_sel_mem;
    logic [1:0] dest_control;
    logic       is_alu;
    logic       is_halt;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/cu_decode.sv
// Combinational opcode decoder: opcode -> control bundle. LOOP/DJNZ decode as
// illegal unless CU_LOOP_EN is defined.
module cu_decode
  import cu_pkg::*;
#(
  parameter int unsigned OP_WIDTH = 4
) (
  input  logic [OP_WIDTH-1:0] opcode,
  output ctrl_t               ctrl
);

  logic       hi_zero;
  logic [3:0] opc;

  // Any set bit above the 4-bit opcode space makes the instruction illegal.
  assign hi_zero = (opcode >> 4) == '0;
  assign opc     = opcode[3:0];

  always_comb begin
    ctrl = '0;
    if (!hi_zero) begin
      ctrl.illegal = 1'b1;
    end else begin
      case (opc)
        OPC_ADD: begin
          ctrl.en_alu = 1'b1;
          ctrl.is_alu = 1'b1;
          ctrl.op_sel = OPSEL_ADD;
        end
        OPC_SUB: begin
          ctrl.en_alu = 1'b1;
          ctrl.is_alu = 1'b1;
          ctrl.op_sel = OPSEL_SUB;
        end
        OPC_MUL: begin
          ctrl.en_alu = 1'b1;
          ctrl.is_alu = 1'b1;
          ctrl.op_sel = OPSEL_MUL;
        end
        OPC_MEMW:   ctrl.en_write_mem = 1'b1;
        OPC_MEMSEL: ctrl.en_sel_mem   = 1'b1;
        OPC_SIG:    ctrl.dest_control = DEST_SIG;
        OPC_RELU:   ctrl.dest_control = DEST_RELU;
        OPC_DSIG:   ctrl.dest_control = DEST_DSIG;
        OPC_LOOP, OPC_DJNZ: begin
`ifdef CU_LOOP_EN
          ctrl.illegal = 1'b0;
`else
          ctrl.illegal = 1'b1;
`endif
        end
        OPC_HALT: ctrl.is_halt = 1'b1;
        OPC_NOP:  ctrl.illegal = 1'b0;
        default:  ctrl.illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/cu_seq.sv
// Autoencoder sequencing control unit: fetch/decode/issue FSM with ALU done
// handshake, HALT, sticky illegal-opcode flag and optional CU_LOOP_EN loops.
module cu_seq
  import cu_pkg::*;
#(
  parameter int unsigned OP_WIDTH   = 4,
  parameter int unsigned PC_WIDTH   = 8,
  parameter int unsigned LOOP_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  output logic [PC_WIDTH-1:0]          instr_addr,
  input  logic [OP_WIDTH+PC_WIDTH-1:0] instr_data,
  input  logic                         alu_done,
  output logic                         en_alu,
  output logic                         en_writeMem,
  output logic                         en_selMem,
  output logic [1:0]                   op_sel,
  output logic [1:0]                   dest_control,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d, pc_inc;
  logic [OP_WIDTH-1:0] opcode;
  ctrl_t               ctrl;

  logic       en_alu_d, en_wm_d, en_sm_d, busy_d, done_d, err_d;
  logic [1:0] op_sel_d, dest_d;

  assign opcode     = instr_data[OP_WIDTH+PC_WIDTH-1 -: OP_WIDTH];
  assign pc_inc     = pc_q + PC_WIDTH'(1);
  assign instr_addr = pc_q;

  cu_decode #(.OP_WIDTH(OP_WIDTH)) u_decode (
    .opcode (opcode),
    .ctrl   (ctrl)
  );

`ifdef CU_LOOP_EN
  logic [PC_WIDTH-1:0]   operand;
  logic [LOOP_WIDTH-1:0] loop_q, loop_d;
  assign operand = instr_data[PC_WIDTH-1:0];
`else
  logic unused_operand;
  assign unused_operand = ^instr_data[PC_WIDTH-1:0];
`endif

  // Next-state, next-pc and next-output logic.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    busy_d   = busy;
    err_d    = err;
    done_d   = 1'b0;
    en_alu_d = 1'b0;
    en_wm_d  = 1'b0;
    en_sm_d  = 1'b0;
    op_sel_d = OPSEL_ADD;
    dest_d   = DEST_NONE;
`ifdef CU_LOOP_EN
    loop_d   = loop_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
          pc_d    = '0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
`ifdef CU_LOOP_EN
          loop_d  = '0;
`endif
        end
      end
      ST_FETCH: state_d = ST_EXEC;
      ST_EXEC: begin
        en_alu_d = ctrl.en_alu;
        op_sel_d = ctrl.op_sel;
        en_wm_d  = ctrl.en_write_mem;
        en_sm_d  = ctrl.en_sel_mem;
        dest_d   = ctrl.dest_control;
        if (ctrl.illegal) err_d = 1'b1;
        if (ctrl.is_halt) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (ctrl.is_alu) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_FETCH;
          pc_d    = pc_inc;
`ifdef CU_LOOP_EN
          // DJNZ branches only while the decremented count stays nonzero.
          if (opcode == OP_WIDTH'(OPC_LOOP)) begin
            loop_d = LOOP_WIDTH'(operand);
          end else if (opcode == OP_WIDTH'(OPC_DJNZ) && loop_q != '0) begin
            loop_d = loop_q - LOOP_WIDTH'(1);
            if (loop_q != LOOP_WIDTH'(1)) pc_d = operand;
          end
`endif
        end
      end
      ST_WAIT: begin
        if (alu_done) begin
          state_d = ST_FETCH;
          pc_d    = pc_inc;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, pc, loop counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pc_q         <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      en_alu       <= 1'b0;
      en_writeMem  <= 1'b0;
      en_selMem    <= 1'b0;
      op_sel       <= 2'b00;
      dest_control <= 2'b00;
`ifdef CU_LOOP_EN
      loop_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      busy         <= busy_d;
      done         <= done_d;
      err          <= err_d;
      en_alu       <= en_alu_d;
      en_writeMem  <= en_wm_d;
      en_selMem    <= en_sm_d;
      op_sel       <= op_sel_d;
      dest_control <= dest_d;
`ifdef CU_LOOP_EN
      loop_q       <= loop_d;
`endif
    end
  end

endmodule
